// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    VEND   = 2'b01,
    CHANGE = 2'b10
  } state_e;

  localparam int unsigned CREDIT_W = 10;
  localparam int unsigned CONV_LAT = 12;

  localparam logic [CREDIT_W-1:0] COIN_5   = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] COIN_10  = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] COIN_25  = CREDIT_W'(25);
  localparam logic [CREDIT_W-1:0] COIN_100 = CREDIT_W'(100);

  // Double-dabble digit correction applied before each shift.
  function automatic logic [3:0] dd_adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/vend_credit_bcd_if.sv
// Front-panel inputs and display/dispense outputs of the credit controller.
interface vend_credit_bcd_if;
  logic        coin_5;
  logic        coin_10;
  logic        coin_25;
  logic        coin_100;
  logic        buy;
  logic        cancel;
  logic [15:0] credit_bcd;
  logic        vend;
  logic        ret_25;
  logic        ret_10;
  logic        ret_5;
  logic        reject;
  logic        busy;

  modport master (
    output coin_5, coin_10, coin_25, coin_100, buy, cancel,
    input  credit_bcd, vend, ret_25, ret_10, ret_5, reject, busy
  );

  modport slave (
    input  coin_5, coin_10, coin_25, coin_100, buy, cancel,
    output credit_bcd, vend, ret_25, ret_10, ret_5, reject, busy
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle, bcd written once with a done pulse.
module bin2bcd_seq
  import vend_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CREDIT_W-1:0] bin,
  output logic                busy,
  output logic                done,
  output logic [15:0]         bcd
);

  logic [CREDIT_W+15:0] sh_q, sh_d, adj;
  logic [3:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [15:0]          bcd_q, bcd_d;

  always_comb begin
    adj = sh_q;
    for (int unsigned i = 0; i < 4; i++) begin
      adj[CREDIT_W+4*i +: 4] = dd_adj(sh_q[CREDIT_W+4*i +: 4]);
    end
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    bcd_d  = bcd_q;
    if (busy_q) begin
      sh_d  = adj << 1;
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        bcd_d  = sh_d[CREDIT_W +: 16];
      end
    end else if (start) begin
      sh_d   = {16'h0000, bin};
      cnt_d  = 4'(CREDIT_W);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q  <= '0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      bcd_q  <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/vend_credit_bcd.sv
// Vending credit controller: coin acceptance, vend, paced change return, BCD credit display.
module vend_credit_bcd
  import vend_pkg::*;
#(
  parameter int unsigned PRICE      = 125,
  parameter int unsigned MAX_CREDIT = 995,
  parameter int unsigned RET_GAP    = 4
) (
  input logic               clk,
  input logic               reset,
  vend_credit_bcd_if.slave  io
);

  localparam int unsigned GAP_W = (RET_GAP > 1) ? $clog2(RET_GAP) : 1;
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   LIMIT_C = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [GAP_W-1:0]    GAP_RELOAD = GAP_W'(RET_GAP - 1);

  state_e state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, add_val;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic ret25_q, ret25_d, ret10_q, ret10_d, ret5_q, ret5_d;
  logic reject_q, reject_d;
  logic [3:0] coins, acc;
  logic fit100, fit25, fit10, fit5;
  logic [15:0] credit_bcd_q;
  logic conv_busy, conv_done;
  logic [15:0] conv_bcd;

  assign coins  = {io.coin_100, io.coin_25, io.coin_10, io.coin_5};
  assign fit100 = ({1'b0, credit_q} + {1'b0, COIN_100}) <= LIMIT_C;
  assign fit25  = ({1'b0, credit_q} + {1'b0, COIN_25})  <= LIMIT_C;
  assign fit10  = ({1'b0, credit_q} + {1'b0, COIN_10})  <= LIMIT_C;
  assign fit5   = ({1'b0, credit_q} + {1'b0, COIN_5})   <= LIMIT_C;

  // Highest-priority asserted coin that still fits is taken; every other asserted coin is refused.
  always_comb begin
    acc     = '0;
    add_val = '0;
    if (coins[3] && fit100) begin
      acc = 4'b1000; add_val = COIN_100;
    end else if (coins[2] && fit25) begin
      acc = 4'b0100; add_val = COIN_25;
    end else if (coins[1] && fit10) begin
      acc = 4'b0010; add_val = COIN_10;
    end else if (coins[0] && fit5) begin
      acc = 4'b0001; add_val = COIN_5;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (io.cancel)                             state_d = CHANGE;
        else if (io.buy && (credit_q >= PRICE_C))  state_d = VEND;
      end
      VEND:    state_d = (credit_q != PRICE_C) ? CHANGE : IDLE;
      CHANGE:  if (credit_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io.busy = (state_q != IDLE);
    io.vend = (state_q == VEND);
  end

  always_comb begin
    credit_d = credit_q;
    gap_d    = gap_q;
    ret25_d  = 1'b0;
    ret10_d  = 1'b0;
    ret5_d   = 1'b0;
    reject_d = |coins;
    unique case (state_q)
      IDLE: begin
        gap_d = '0;
        if (!io.cancel) begin
          credit_d = credit_q + add_val;
          reject_d = |(coins & ~acc);
        end
      end
      VEND: begin
        gap_d    = '0;
        credit_d = credit_q - PRICE_C;
      end
      CHANGE: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (credit_q != '0) begin
          gap_d = GAP_RELOAD;
          if (credit_q >= COIN_25) begin
            ret25_d = 1'b1; credit_d = credit_q - COIN_25;
          end else if (credit_q >= COIN_10) begin
            ret10_d = 1'b1; credit_d = credit_q - COIN_10;
          end else begin
            ret5_d = 1'b1; credit_d = credit_q - COIN_5;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_q     <= '0;
      gap_q        <= '0;
      ret25_q      <= 1'b0;
      ret10_q      <= 1'b0;
      ret5_q       <= 1'b0;
      reject_q     <= 1'b0;
      credit_bcd_q <= '0;
    end else begin
      credit_q <= credit_d;
      gap_q    <= gap_d;
      ret25_q  <= ret25_d;
      ret10_q  <= ret10_d;
      ret5_q   <= ret5_d;
      reject_q <= reject_d;
      if (conv_done) credit_bcd_q <= conv_bcd;
    end
  end

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (!conv_busy),
    .bin   (credit_q),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign io.ret_25     = ret25_q;
  assign io.ret_10     = ret10_q;
  assign io.ret_5      = ret5_q;
  assign io.reject     = reject_q;
  assign io.credit_bcd = credit_bcd_q;

endmodule

// File: tb/tb_vend_credit_bcd.sv
// Scoreboard bench: transaction-level credit model feeds expected pulse queues, a monitor checks them.
module tb_vend_credit_bcd;
  import vend_pkg::*;

  localparam int unsigned PRICE      = 125;
  localparam int unsigned MAX_CREDIT = 995;
  localparam int unsigned RET_GAP    = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vend_credit_bcd_if io();

  vend_credit_bcd #(.PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .RET_GAP(RET_GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  typedef enum int {EV_VEND, EV_R25, EV_R10, EV_R5, EV_NONE, EV_MULTI} ev_e;
  typedef struct {
    ev_e kind;
    int  gap;       // 0: first of a burst, else exact cycles after previous pulse
    int  deadline;  // latest cycle for a first-of-burst pulse
  } exp_t;

  exp_t out_q[$];
  int   rej_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   m_credit = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int c);
    return {4'((c / 1000) % 10), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  // Monitor: checks every pulse output against the expectation queues.
  initial begin
    ev_e obs;
    int  npulse;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rej_q.size() > 0 && rej_q[0] == cyc) begin
          chk(io.reject === 1'b1, "reject_pulse", int'(io.reject), 1);
          void'(rej_q.pop_front());
        end else if (io.reject !== 1'b0) begin
          chk(1'b0, "reject_unexpected", int'(io.reject), 0);
        end

        npulse = int'(io.vend) + int'(io.ret_25) + int'(io.ret_10) + int'(io.ret_5);
        if (npulse > 1)        obs = EV_MULTI;
        else if (io.vend)      obs = EV_VEND;
        else if (io.ret_25)    obs = EV_R25;
        else if (io.ret_10)    obs = EV_R10;
        else if (io.ret_5)     obs = EV_R5;
        else                   obs = EV_NONE;

        if (out_q.size() == 0) begin
          if (obs != EV_NONE) chk(1'b0, "pulse_unexpected", int'(obs), int'(EV_NONE));
        end else if (out_q[0].gap != 0) begin
          if (cyc == last_cyc + out_q[0].gap) begin
            chk(obs == out_q[0].kind, "ret_order_gap", int'(obs), int'(out_q[0].kind));
            last_cyc = cyc;
            void'(out_q.pop_front());
          end else if (obs != EV_NONE) begin
            chk(1'b0, "pulse_early", int'(obs), int'(EV_NONE));
          end
        end else begin
          if (obs != EV_NONE) begin
            chk(obs == out_q[0].kind, "first_pulse", int'(obs), int'(out_q[0].kind));
            last_cyc = cyc;
            void'(out_q.pop_front());
          end else if (cyc > out_q[0].deadline) begin
            chk(1'b0, "pulse_timeout", int'(obs), int'(out_q[0].kind));
            void'(out_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [3:0] coins, input logic b, input logic cn);
    io.coin_100 = coins[3];
    io.coin_25  = coins[2];
    io.coin_10  = coins[1];
    io.coin_5   = coins[0];
    io.buy      = b;
    io.cancel   = cn;
    @(posedge clk); #1;
    io.coin_100 = 1'b0; io.coin_25 = 1'b0; io.coin_10 = 1'b0; io.coin_5 = 1'b0;
    io.buy      = 1'b0; io.cancel  = 1'b0;
  endtask

  // Greedy change payout of amount c, pulses RET_GAP apart.
  task automatic push_change(input int c, input int issue);
    exp_t e;
    bit   first = 1'b1;
    while (c > 0) begin
      if (c >= 25)      begin e.kind = EV_R25; c -= 25; end
      else if (c >= 10) begin e.kind = EV_R10; c -= 10; end
      else              begin e.kind = EV_R5;  c -= 5;  end
      e.gap      = first ? 0 : int'(RET_GAP);
      e.deadline = issue + 4;
      out_q.push_back(e);
      first = 1'b0;
    end
  endtask

  // One cycle of stimulus while the controller is known to be idle.
  task automatic idle_cycle(input logic [3:0] coins, input logic b, input logic cn,
                            output bit went_busy);
    int   vals[4] = '{5, 10, 25, 100};
    int   issue = cyc;
    int   old = m_credit;
    int   taken = 0;
    bit   rej = 1'b0;
    exp_t e;
    went_busy = 1'b0;
    if (cn) begin
      rej = |coins;
      push_change(m_credit, issue);
      m_credit  = 0;
      went_busy = 1'b1;
    end else begin
      for (int k = 3; k >= 0; k--) begin
        if (coins[k]) begin
          if (taken == 0 && m_credit + vals[k] <= int'(MAX_CREDIT)) taken = vals[k];
          else rej = 1'b1;
        end
      end
      m_credit += taken;
      if (b && old >= int'(PRICE)) begin
        e.kind = EV_VEND; e.gap = 0; e.deadline = issue + 1;
        out_q.push_back(e);
        m_credit -= int'(PRICE);
        push_change(m_credit, issue);
        m_credit  = 0;
        went_busy = 1'b1;
      end
    end
    if (rej) rej_q.push_back(issue + 1);
    drive(coins, b, cn);
  endtask

  task automatic busy_cycle(input logic [3:0] coins, input logic b, input logic cn);
    if (|coins) rej_q.push_back(cyc + 1);
    drive(coins, b, cn);
  endtask

  task automatic wait_idle(output int k);
    for (k = 0; k < 600; k++) begin
      if (io.busy === 1'b0 && out_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk(k < 600, "idle_timeout", k, 600);
  endtask

  task automatic show(input logic [15:0] exp, input string name);
    repeat (2 * CONV_LAT + 6) begin @(posedge clk); #1; end
    chk(io.credit_bcd === exp, name, int'(io.credit_bcd), int'(exp));
  endtask

  initial begin
    bit wb;
    int k;
    io.coin_5 = 1'b0; io.coin_10 = 1'b0; io.coin_25 = 1'b0; io.coin_100 = 1'b0;
    io.buy = 1'b0; io.cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(io.credit_bcd === 16'h0000, "reset_bcd", int'(io.credit_bcd), 0);
    reset = 1'b0;

    repeat (30) begin @(posedge clk); #1; end
    chk(io.credit_bcd === 16'h0000, "idle_bcd", int'(io.credit_bcd), 0);
    chk(io.busy === 1'b0, "idle_busy", int'(io.busy), 0);
    chk({io.vend, io.ret_25, io.ret_10, io.ret_5, io.reject} === 5'b0, "idle_pulses",
        int'({io.vend, io.ret_25, io.ret_10, io.ret_5, io.reject}), 0);

    idle_cycle(4'b0100, 1'b0, 1'b0, wb);
    idle_cycle(4'b1000, 1'b0, 1'b0, wb);
    idle_cycle(4'b0010, 1'b0, 1'b0, wb);
    show(16'h0135, "bcd_135");

    idle_cycle(4'b0000, 1'b1, 1'b0, wb);
    chk(io.busy === 1'b1, "busy_in_vend", int'(io.busy), 1);
    wait_idle(k);
    chk(k <= int'(RET_GAP) + 2, "idle_latency", k, int'(RET_GAP) + 2);
    show(16'h0000, "bcd_after_vend");

    repeat (9) idle_cycle(4'b1000, 1'b0, 1'b0, wb);
    repeat (3) idle_cycle(4'b0100, 1'b0, 1'b0, wb);
    idle_cycle(4'b0010, 1'b0, 1'b0, wb);
    idle_cycle(4'b0001, 1'b0, 1'b0, wb);
    idle_cycle(4'b0010, 1'b0, 1'b0, wb);
    show(16'h0990, "bcd_990_dime_refused");
    idle_cycle(4'b0000, 1'b0, 1'b1, wb);
    wait_idle(k);
    repeat (9) idle_cycle(4'b1000, 1'b0, 1'b0, wb);
    repeat (3) idle_cycle(4'b0100, 1'b0, 1'b0, wb);
    idle_cycle(4'b0010, 1'b0, 1'b0, wb);
    idle_cycle(4'b0101, 1'b0, 1'b0, wb);
    show(16'h0990, "bcd_990_nickel_taken");
    idle_cycle(4'b0000, 1'b0, 1'b1, wb);
    wait_idle(k);

    idle_cycle(4'b0100, 1'b0, 1'b0, wb);
    idle_cycle(4'b0010, 1'b0, 1'b0, wb);
    idle_cycle(4'b0001, 1'b0, 1'b0, wb);
    idle_cycle(4'b0000, 1'b0, 1'b1, wb);
    busy_cycle(4'b0100, 1'b1, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    busy_cycle(4'b0001, 1'b0, 1'b1);
    wait_idle(k);
    show(16'h0000, "bcd_after_cancel");

    idle_cycle(4'b0100, 1'b0, 1'b0, wb);
    idle_cycle(4'b0010, 1'b0, 1'b0, wb);
    idle_cycle(4'b0001, 1'b0, 1'b0, wb);
    idle_cycle(4'b0000, 1'b0, 1'b1, wb);
    for (k = 0; k < 20 && out_q.size() > 2; k++) begin @(posedge clk); #1; end
    chk(out_q.size() == 2, "first_ret_before_reset", out_q.size(), 2);
    reset = 1'b1;
    out_q.delete();
    rej_q.delete();
    m_credit = 0;
    #2;
    chk(io.credit_bcd === 16'h0000, "reset_mid_change_bcd", int'(io.credit_bcd), 0);
    chk(io.busy === 1'b0, "reset_mid_change_busy", int'(io.busy), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3 * RET_GAP + 4) begin @(posedge clk); #1; end
    show(16'h0000, "bcd_after_reset");

    for (int it = 0; it < 60; it++) begin
      wb = 1'b0;
      for (int c = 0; c < 6 && !wb; c++) begin
        int r;
        logic [3:0] coins;
        logic b, cn;
        r = $urandom_range(0, 9);
        case (r)
          0, 1:    coins = 4'b1000;
          2:       coins = 4'b0100;
          3:       coins = 4'b0010;
          4:       coins = 4'b0001;
          5, 6:    coins = 4'($urandom_range(0, 15));
          default: coins = 4'b0000;
        endcase
        b  = ($urandom_range(0, 5) == 0);
        cn = ($urandom_range(0, 11) == 0);
        idle_cycle(coins, b, cn, wb);
      end
      if (wb) begin
        if ($urandom_range(0, 1) == 1)
          busy_cycle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        wait_idle(k);
      end
      show(to_bcd(m_credit), "bcd_random");
    end

    repeat (5) begin @(posedge clk); #1; end
    chk(out_q.size() == 0 && rej_q.size() == 0, "queues_drained",
        out_q.size() + rej_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
